pool2x2_stream: RTL and testbench

// - Streaming 2x2/stride-2 pooling engine for feature maps arriving in raster order, one pixel (CH lanes) per beat.
// - Successor to the combinational 4-to-1 max comparator: handles row pairing internally via a half-width line buffer.
// - Sits between the CNN conv/ReLU output stream and the next layer's input buffer; valid/ready on both sides.

---
 rtl/pool2x2_stream_if.sv | 39 +++
 rtl/pool2x2_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_pool2x2_stream.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool2x2_stream_if.sv
// Streaming handshake bundle for pool2x2_stream.
// Input side: in_valid/in_ready/in_data. Output side: out_valid/out_ready/out_data/out_last.
// When POOL_AVG_EN is defined, the bundle also carries the per-beat mode select (0=max, 1=average).
// The slave modport is the pooling engine's view; the master modport is the view of the surrounding logic.
interface pool2x2_stream_if #(
    parameter int DATA_W = 8,
    parameter int CH     = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [CH*DATA_W-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [CH*DATA_W-1:0]   out_data;
    logic                   out_last;
`ifdef POOL_AVG_EN
    logic                   mode;

    modport slave (
        input  in_valid, in_data, out_ready, mode,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready, mode,
        input  in_ready, out_valid, out_data, out_last
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
`endif
endinterface

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming 2x2 / stride-2 pooling over raster-order pixels, CH signed lanes per beat.
// The top row of each window pair is reduced into a half-width line buffer; the bottom row
// completes the window and loads a single output register (no skid buffer).
// Optional feature macro: POOL_AVG_EN adds the mode input and the average-pooling path
// (line buffer and hold register widen to DATA_W+1 bits per lane to keep pair sums).
module pool2x2_stream #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    pool2x2_stream_if.slave  bus
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int LB_D  = IMG_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
`ifdef POOL_AVG_EN
    localparam int HW    = DATA_W + 1;
    localparam int SW    = DATA_W + 2;
`else
    localparam int HW    = DATA_W;
`endif
    localparam int PW    = CH * DATA_W;
    localparam int HPW   = CH * HW;

    if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
        $error("pool2x2_stream: IMG_W must be even and >= 2");
    end
    if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
        $error("pool2x2_stream: IMG_H must be even and >= 2");
    end

    // Window phase is implied by the low bits of the counters: {row[0], col[0]}.
    typedef enum logic [1:0] {
        EVEN_L = 2'b00,
        EVEN_R = 2'b01,
        ODD_L  = 2'b10,
        ODD_R  = 2'b11
    } phase_e;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [HPW-1:0]   hold_q, hold_d;
    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic [HPW-1:0]   lb_mem [LB_D];
    logic [HPW-1:0]   lb_rd_s;
    logic [LB_AW-1:0] lb_idx_s;
    logic             lb_we_s;

    phase_e           phase_s;
    logic             in_ready_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             last_col_s;
    logic             last_row_s;
    logic [HPW-1:0]   px_wide_s;
    logic [HPW-1:0]   pair_s;
    logic [PW-1:0]    res_s;

    // Sign-extend one input lane to the hold/line-buffer lane width.
    function automatic logic signed [HW-1:0] widen_f(input logic [DATA_W-1:0] v);
        return HW'($signed(v));
    endfunction

    // Per-lane signed maximum; on a tie either operand is the same value.
    function automatic logic signed [HW-1:0] max_f(input logic signed [HW-1:0] a,
                                                   input logic signed [HW-1:0] b);
        return (a > b) ? a : b;
    endfunction

`ifdef POOL_AVG_EN
    // Horizontal pair reduction: sum (average mode) or max.
    function automatic logic signed [HW-1:0] pair_f(input logic signed [HW-1:0] a,
                                                    input logic signed [HW-1:0] b,
                                                    input logic             avg);
        if (avg) begin
            return a + b;
        end else begin
            return max_f(a, b);
        end
    endfunction

    // Window result: 4-sum floored by arithmetic shift, or max of the two pair results.
    function automatic logic [DATA_W-1:0] final_f(input logic signed [HW-1:0] top,
                                                  input logic signed [HW-1:0] bot,
                                                  input logic             avg);
        logic signed [SW-1:0] sum4;
        sum4 = SW'(top) + SW'(bot);
        if (avg) begin
            return DATA_W'(sum4 >>> 2);
        end else begin
            return DATA_W'(max_f(top, bot));
        end
    endfunction

    logic mode_s;
    assign mode_s = bus.mode;
`else
    // Horizontal pair reduction (max-only build).
    function automatic logic signed [HW-1:0] pair_f(input logic signed [HW-1:0] a,
                                                    input logic signed [HW-1:0] b);
        return max_f(a, b);
    endfunction

    // Window result: max of the top-row and bottom-row pair results.
    function automatic logic [DATA_W-1:0] final_f(input logic signed [HW-1:0] top,
                                                  input logic signed [HW-1:0] bot);
        return DATA_W'(max_f(top, bot));
    endfunction
`endif

    assign in_ready_s   = !out_valid_q || bus.out_ready;
    assign in_fire_s    = bus.in_valid && in_ready_s;
    assign out_fire_s   = out_valid_q && bus.out_ready;
    assign phase_s      = phase_e'({row_q[0], col_q[0]});
    assign last_col_s   = (col_q == COL_W'(IMG_W - 1));
    assign last_row_s   = (row_q == ROW_W'(IMG_H - 1));
    assign lb_idx_s     = LB_AW'(col_q >> 1);
    assign lb_rd_s      = lb_mem[lb_idx_s];
    assign lb_we_s      = in_fire_s && (phase_s == EVEN_R);

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    // Per-lane datapath: widened pixel, pair reduction with the held pixel, window result.
    always_comb begin
        px_wide_s = '0;
        pair_s    = '0;
        res_s     = '0;
        for (int i = 0; i < CH; i++) begin
            px_wide_s[i*HW +: HW] = widen_f(bus.in_data[i*DATA_W +: DATA_W]);
`ifdef POOL_AVG_EN
            pair_s[i*HW +: HW]    = pair_f(hold_q[i*HW +: HW], px_wide_s[i*HW +: HW], mode_s);
            res_s[i*DATA_W +: DATA_W] = final_f(lb_rd_s[i*HW +: HW], pair_s[i*HW +: HW], mode_s);
`else
            pair_s[i*HW +: HW]    = pair_f(hold_q[i*HW +: HW], px_wide_s[i*HW +: HW]);
            res_s[i*DATA_W +: DATA_W] = final_f(lb_rd_s[i*HW +: HW], pair_s[i*HW +: HW]);
`endif
        end
    end

    // Next-state: raster counters, hold register and output register updates.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (in_fire_s) begin
            if (last_col_s) begin
                col_d = '0;
                if (last_row_s) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end

            case (phase_s)
                EVEN_L, ODD_L: begin
                    hold_d = px_wide_s;
                end
                EVEN_R: begin
                    hold_d = hold_q;
                end
                ODD_R: begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_s;
                    out_last_d  = last_col_s && last_row_s;
                end
                default: begin
                    hold_d = hold_q;
                end
            endcase
        end else begin
            col_d = col_q;
        end

        // A drain without a simultaneous ODD_R load empties the output register.
        if (out_fire_s && !(in_fire_s && (phase_s == ODD_R))) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_d;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line buffer: top-row pair results, written at each EVEN_R beat and read at ODD_R.
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            lb_mem[lb_idx_s] <= pair_s;
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Testbench for pool2x2_stream: table-driven 4x2 frames on a CH=4 instance, backpressure,
// reset-mid-frame and latency sequences, plus two random 28x28 frames against a max model.
module tb_pool2x2_stream;

    localparam int DW = 8;
    localparam int CH = 4;
    localparam int BW = 28;
    localparam int BH = 28;
    localparam int NPX = BW * BH;
    localparam int NOUT = (BW / 2) * (BH / 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst_n;
    logic b_rst_n;

    pool2x2_stream_if #(.DATA_W(DW), .CH(CH)) a_if ();
    pool2x2_stream_if #(.DATA_W(DW), .CH(CH)) b_if ();

    pool2x2_stream #(.DATA_W(DW), .CH(CH), .IMG_W(4), .IMG_H(2)) dut_a (
        .clk   (clk),
        .rst_n (a_rst_n),
        .bus   (a_if.slave)
    );

    pool2x2_stream #(.DATA_W(DW), .CH(CH), .IMG_W(BW), .IMG_H(BH)) dut_b (
        .clk   (clk),
        .rst_n (b_rst_n),
        .bus   (b_if.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] a_q[$];
    bit          a_lq[$];
    logic [31:0] b_q[$];
    bit          b_lq[$];
    logic [31:0] pix [2*NPX];
    logic [31:0] exp_b[$];
    bit          b_done;

    typedef struct packed {
        logic            mode;
        logic [7:0][31:0] px;
        logic [31:0]     e0;
        logic [31:0]     e1;
    } vec_t;

    vec_t vtab[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    function automatic logic [31:0] rep(input int v);
        return pk(v, v, v, v);
    endfunction

    function automatic logic [31:0] max4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        logic signed [7:0] m;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            m = $signed(a[l*8 +: 8]);
            if ($signed(b[l*8 +: 8]) > m) m = $signed(b[l*8 +: 8]);
            if ($signed(c[l*8 +: 8]) > m) m = $signed(c[l*8 +: 8]);
            if ($signed(d[l*8 +: 8]) > m) m = $signed(d[l*8 +: 8]);
            r[l*8 +: 8] = m;
        end
        return r;
    endfunction

    // Output monitors: record each completed output handshake.
    always @(negedge clk) begin
        if (a_rst_n && a_if.out_valid && a_if.out_ready) begin
            a_q.push_back(a_if.out_data);
            a_lq.push_back(a_if.out_last);
        end
        if (b_rst_n && b_if.out_valid && b_if.out_ready) begin
            b_q.push_back(b_if.out_data);
            b_lq.push_back(b_if.out_last);
        end
    end

    // Send one beat to dut_a, waiting (bounded) for in_ready. Called at posedge+1.
    task automatic a_send(input logic [31:0] d);
        int n;
        n = 0;
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        @(negedge clk);
        while (!a_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_if.in_ready) begin
            checks++;
            errors++;
            $display("FAIL a_send_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
    endtask

    // Send one beat to dut_b with random in_valid gaps. Called at posedge+1.
    task automatic b_send(input logic [31:0] d);
        bit fired;
        int n;
        fired = 1'b0;
        n = 0;
        b_if.in_data = d;
        while (!fired && n < 200) begin
            b_if.in_valid = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            fired = b_if.in_valid && b_if.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        b_if.in_valid = 1'b0;
        if (!fired) begin
            checks++;
            errors++;
            $display("FAIL b_send_timeout: got no accept expected accept");
        end
    endtask

    task automatic a_wait_outputs(input int cnt);
        for (int n = 0; n < 10 && a_q.size() < cnt; n++) @(posedge clk);
        #1;
    endtask

    task automatic a_check_frame(input string tag, input logic [31:0] e0, input logic [31:0] e1);
        check({tag, "_count"}, 32'(a_q.size()), 32'd2);
        check({tag, "_data0"}, (a_q.size() > 0) ? a_q[0] : 32'hxxxxxxxx, e0);
        check({tag, "_data1"}, (a_q.size() > 1) ? a_q[1] : 32'hxxxxxxxx, e1);
        check({tag, "_last0"}, (a_lq.size() > 0) ? 32'(a_lq[0]) : 32'hxxxxxxxx, 32'd0);
        check({tag, "_last1"}, (a_lq.size() > 1) ? 32'(a_lq[1]) : 32'hxxxxxxxx, 32'd1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [31:0] px_mix [8];

        // ---------- stimulus table ----------
        v.mode = 1'b0;
        v.px[0] = rep(1);    v.px[1] = rep(5);    v.px[2] = rep(-3);  v.px[3] = rep(-7);
        v.px[4] = rep(2);    v.px[5] = rep(-128); v.px[6] = rep(127); v.px[7] = rep(0);
        v.e0 = rep(5);
        v.e1 = rep(127);
        vtab.push_back(v);

        for (int k = 0; k < 8; k++) v.px[k] = rep(-128);
        v.px[4] = pk(-128, -128, 127, -128);
        v.px[3] = pk(-128, -128, 127, -128);
        v.e0 = pk(-128, -128, 127, -128);
        v.e1 = pk(-128, -128, 127, -128);
        vtab.push_back(v);

        for (int k = 0; k < 8; k++) begin
            px_mix[k] = pk(-5, -(k + 1), 10 * (k + 1), (k == 5) ? -1 : ((k == 7) ? 1 : 0));
            v.px[k] = px_mix[k];
        end
        v.e0 = pk(-5, -1, 60, 0);
        v.e1 = pk(-5, -3, 80, 1);
        vtab.push_back(v);
`ifdef POOL_AVG_EN
        v.mode = 1'b1;
        v.px[0] = rep(1);    v.px[1] = rep(5);    v.px[2] = rep(-3);  v.px[3] = rep(-7);
        v.px[4] = rep(2);    v.px[5] = rep(-128); v.px[6] = rep(127); v.px[7] = rep(0);
        v.e0 = rep(-30);
        v.e1 = rep(29);
        vtab.push_back(v);

        for (int k = 0; k < 8; k++) v.px[k] = px_mix[k];
        v.e0 = pk(-5, -4, 35, -1);
        v.e1 = pk(-5, -6, 55, 0);
        vtab.push_back(v);
`endif

        // ---------- reset ----------
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
`ifdef POOL_AVG_EN
        a_if.mode = 1'b0;
        b_if.mode = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_out_data", a_if.out_data, 32'd0);
        check("rst_out_last", 32'(a_if.out_last), 32'd0);
        check("rst_in_ready", 32'(a_if.in_ready), 32'd1);
        check("rst_b_out_valid", 32'(b_if.out_valid), 32'd0);

        // ---------- table-driven frames ----------
        a_if.out_ready = 1'b1;
        for (int t = 0; t < vtab.size(); t++) begin
            a_q.delete();
            a_lq.delete();
`ifdef POOL_AVG_EN
            a_if.mode = vtab[t].mode;
`endif
            for (int k = 0; k < 8; k++) a_send(vtab[t].px[k]);
            a_wait_outputs(2);
            a_check_frame($sformatf("vec%0d", t), vtab[t].e0, vtab[t].e1);
        end
`ifdef POOL_AVG_EN
        a_if.mode = 1'b0;
`endif

        // ---------- latency and backpressure ----------
        a_q.delete();
        a_lq.delete();
        a_if.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) a_send(vtab[0].px[k]);
        check("lat_before", 32'(a_if.out_valid), 32'd0);
        a_send(vtab[0].px[5]);
        check("lat_after", 32'(a_if.out_valid), 32'd1);
        a_if.in_valid = 1'b1;
        a_if.in_data  = vtab[0].px[6];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(a_if.in_ready), 32'd0);
            check("bp_out_valid", 32'(a_if.out_valid), 32'd1);
            check("bp_out_data", a_if.out_data, rep(5));
            check("bp_out_last", 32'(a_if.out_last), 32'd0);
        end
        @(posedge clk);
        #1;
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        a_send(vtab[0].px[6]);
        a_send(vtab[0].px[7]);
        a_wait_outputs(2);
        a_check_frame("bp", rep(5), rep(127));

        // ---------- reset drops a pending output ----------
        a_q.delete();
        a_lq.delete();
        a_if.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) a_send(vtab[0].px[k]);
        a_rst_n = 1'b0;
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        check("rstp_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rstp_out_data", a_if.out_data, 32'd0);
        check("rstp_in_ready", 32'(a_if.in_ready), 32'd1);

        // ---------- reset at pixel (1,3) then a full frame ----------
        a_if.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) a_send(vtab[2].px[k]);
        a_wait_outputs(1);
        check("rstm_partial_count", 32'(a_q.size()), 32'd1);
        check("rstm_partial_data", (a_q.size() > 0) ? a_q[0] : 32'hxxxxxxxx, vtab[2].e0);
        a_if.in_valid = 1'b1;
        a_if.in_data  = vtab[2].px[7];
        a_rst_n = 1'b0;
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        a_if.in_valid = 1'b0;
        check("rstm_out_valid", 32'(a_if.out_valid), 32'd0);
        a_q.delete();
        a_lq.delete();
        for (int k = 0; k < 8; k++) a_send(vtab[0].px[k]);
        a_wait_outputs(2);
        a_check_frame("rstm", rep(5), rep(127));

        // ---------- two back-to-back random 28x28 frames ----------
        for (int i = 0; i < 2 * NPX; i++) pix[i] = $urandom;
        for (int f = 0; f < 2; f++) begin
            for (int wr = 0; wr < BH / 2; wr++) begin
                for (int wc = 0; wc < BW / 2; wc++) begin
                    int base;
                    base = f * NPX + (2 * wr) * BW + 2 * wc;
                    exp_b.push_back(max4(pix[base], pix[base + 1], pix[base + BW], pix[base + BW + 1]));
                end
            end
        end
        b_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 2 * NPX; i++) b_send(pix[i]);
                b_done = 1'b1;
            end
            begin
                while (!b_done) begin
                    b_if.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                b_if.out_ready = 1'b1;
            end
        join
        for (int n = 0; n < 50 && b_q.size() < 2 * NOUT; n++) @(posedge clk);
        #1;
        check("rand_count", 32'(b_q.size()), 32'(2 * NOUT));
        for (int i = 0; i < 2 * NOUT; i++) begin
            check($sformatf("rand_data%0d", i), (i < b_q.size()) ? b_q[i] : 32'hxxxxxxxx, exp_b[i]);
            check($sformatf("rand_last%0d", i), (i < b_lq.size()) ? 32'(b_lq[i]) : 32'hxxxxxxxx,
                  ((i == NOUT - 1) || (i == 2 * NOUT - 1)) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
